lc3_decode_stage: RTL and testbench

LC3_DECODE_STAGE -- requirements
Module: lc3_decode_stage

---
 rtl/lc3_decode_stage.sv | 163 ++++++++++++++++
 tb/tb_lc3_decode_stage.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/lc3_decode_stage.sv
// LC-3 decode stage: registers the fetched instruction and NPC and produces
// execute/writeback/memory control fields one cycle after each accept.
module lc3_decode_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_decode,
    input  logic [15:0] Instr_dout,
    input  logic [15:0] npc_in,
    output logic [15:0] IR,
    output logic [15:0] npc_out,
    output logic [5:0]  E_Control,
    output logic [1:0]  W_Control,
    output logic        Mem_Control,
    output logic        decode_valid,
    output logic        illegal_op,
    output logic [15:0] decode_count
);

    typedef enum logic [3:0] {
        OpBr  = 4'b0000,
        OpAdd = 4'b0001,
        OpLd  = 4'b0010,
        OpSt  = 4'b0011,
        OpAnd = 4'b0101,
        OpLdr = 4'b0110,
        OpStr = 4'b0111,
        OpNot = 4'b1001,
        OpLdi = 4'b1010,
        OpSti = 4'b1011,
        OpJmp = 4'b1100,
        OpLea = 4'b1110
    } opcode_e;

    localparam logic [1:0] WbAlu = 2'b00;
    localparam logic [1:0] WbPc  = 2'b01;
    localparam logic [1:0] WbMem = 2'b10;

    logic [3:0]  opcode;
    logic [1:0]  alu_control;
    logic [1:0]  pcselect1;
    logic        pcselect2;
    logic        op2select;
    logic [1:0]  w_ctrl;
    logic        mem_ctrl;
    logic        illegal;

    logic [15:0] ir_q, ir_d;
    logic [15:0] npc_q, npc_d;
    logic [5:0]  e_ctrl_q, e_ctrl_d;
    logic [1:0]  w_ctrl_q, w_ctrl_d;
    logic        mem_ctrl_q, mem_ctrl_d;
    logic        valid_q, valid_d;
    logic        illegal_q, illegal_d;
    logic [15:0] count_q, count_d;

    assign opcode = Instr_dout[15:12];

    // Unsupported opcodes fall through to the default arm with all controls zeroed.
    always_comb begin
        alu_control = 2'b00;
        pcselect1   = 2'b00;
        pcselect2   = 1'b0;
        op2select   = 1'b0;
        w_ctrl      = WbAlu;
        mem_ctrl    = 1'b0;
        illegal     = 1'b0;
        case (opcode)
            OpAdd: begin
                alu_control = 2'b00;
                op2select   = ~Instr_dout[5];
            end
            OpAnd: begin
                alu_control = 2'b01;
                op2select   = ~Instr_dout[5];
            end
            OpNot: alu_control = 2'b10;
            OpBr, OpSt: begin
                pcselect1 = 2'b01;
                pcselect2 = 1'b1;
            end
            OpLd: begin
                pcselect1 = 2'b01;
                pcselect2 = 1'b1;
                w_ctrl    = WbMem;
            end
            OpLdi: begin
                pcselect1 = 2'b01;
                pcselect2 = 1'b1;
                w_ctrl    = WbMem;
                mem_ctrl  = 1'b1;
            end
            OpSti: begin
                pcselect1 = 2'b01;
                pcselect2 = 1'b1;
                mem_ctrl  = 1'b1;
            end
            OpLea: begin
                pcselect1 = 2'b01;
                pcselect2 = 1'b1;
                w_ctrl    = WbPc;
            end
            OpLdr: begin
                pcselect1 = 2'b10;
                w_ctrl    = WbMem;
            end
            OpStr: pcselect1 = 2'b10;
            OpJmp: pcselect1 = 2'b11;
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        ir_d       = ir_q;
        npc_d      = npc_q;
        e_ctrl_d   = e_ctrl_q;
        w_ctrl_d   = w_ctrl_q;
        mem_ctrl_d = mem_ctrl_q;
        illegal_d  = illegal_q;
        count_d    = count_q;
        valid_d    = enable_decode;
        if (enable_decode) begin
            ir_d       = Instr_dout;
            npc_d      = npc_in;
            e_ctrl_d   = {alu_control, pcselect1, pcselect2, op2select};
            w_ctrl_d   = w_ctrl;
            mem_ctrl_d = mem_ctrl;
            illegal_d  = illegal;
            count_d    = count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ir_q       <= '0;
            npc_q      <= '0;
            e_ctrl_q   <= '0;
            w_ctrl_q   <= '0;
            mem_ctrl_q <= 1'b0;
            valid_q    <= 1'b0;
            illegal_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            ir_q       <= ir_d;
            npc_q      <= npc_d;
            e_ctrl_q   <= e_ctrl_d;
            w_ctrl_q   <= w_ctrl_d;
            mem_ctrl_q <= mem_ctrl_d;
            valid_q    <= valid_d;
            illegal_q  <= illegal_d;
            count_q    <= count_d;
        end
    end

    assign IR           = ir_q;
    assign npc_out      = npc_q;
    assign E_Control    = e_ctrl_q;
    assign W_Control    = w_ctrl_q;
    assign Mem_Control  = mem_ctrl_q;
    assign decode_valid = valid_q;
    assign illegal_op   = illegal_q;
    assign decode_count = count_q;

endmodule

// File: tb/tb_lc3_decode_stage.sv
// Scoreboard bench for lc3_decode_stage: the driver pushes the expected post-edge
// output state per cycle; a monitor pops and compares it after each rising edge.
module tb_lc3_decode_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable_decode;
    logic [15:0] Instr_dout;
    logic [15:0] npc_in;
    logic [15:0] IR;
    logic [15:0] npc_out;
    logic [5:0]  E_Control;
    logic [1:0]  W_Control;
    logic        Mem_Control;
    logic        decode_valid;
    logic        illegal_op;
    logic [15:0] decode_count;

    lc3_decode_stage dut (
        .clock        (clock),
        .reset        (reset),
        .enable_decode(enable_decode),
        .Instr_dout   (Instr_dout),
        .npc_in       (npc_in),
        .IR           (IR),
        .npc_out      (npc_out),
        .E_Control    (E_Control),
        .W_Control    (W_Control),
        .Mem_Control  (Mem_Control),
        .decode_valid (decode_valid),
        .illegal_op   (illegal_op),
        .decode_count (decode_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [15:0] ir;
        logic [15:0] npc;
        logic [5:0]  e;
        logic [1:0]  w;
        logic        m;
        logic        v;
        logic        ill;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t model;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pushed = 0;
    int   n_popped = 0;
    bit   done     = 1'b0;

    // Drive one cycle; e/w/m/ill are the hand-computed controls for instr.
    task automatic cycle(input string name, input logic rst, input logic en,
                         input logic [15:0] instr, input logic [15:0] npc,
                         input logic [5:0] e, input logic [1:0] w,
                         input logic m, input logic ill);
        @(negedge clock);
        reset         = rst;
        enable_decode = en;
        Instr_dout    = instr;
        npc_in        = npc;
        @(posedge clock);
        model.name = name;
        if (rst) begin
            model.ir = '0; model.npc = '0; model.e = '0; model.w = '0;
            model.m = 1'b0; model.v = 1'b0; model.ill = 1'b0; model.cnt = '0;
        end else if (en) begin
            model.ir = instr; model.npc = npc; model.e = e; model.w = w;
            model.m = m; model.v = 1'b1; model.ill = ill; model.cnt = model.cnt + 16'd1;
        end else begin
            model.v = 1'b0;
        end
        q.push_back(model);
        n_pushed++;
    endtask

    always @(posedge clock) begin
        exp_t x;
        #2;
        if (q.size() > 0) begin
            x = q.pop_front();
            n_popped++;
            n_checks++;
            if (IR !== x.ir || npc_out !== x.npc || E_Control !== x.e || W_Control !== x.w ||
                Mem_Control !== x.m || decode_valid !== x.v || illegal_op !== x.ill ||
                decode_count !== x.cnt) begin
                n_fail++;
                $display("FAIL %s: got IR=%h npc=%h E=%b W=%b M=%b V=%b ILL=%b CNT=%h exp IR=%h npc=%h E=%b W=%b M=%b V=%b ILL=%b CNT=%h",
                         x.name, IR, npc_out, E_Control, W_Control, Mem_Control,
                         decode_valid, illegal_op, decode_count, x.ir, x.npc, x.e, x.w,
                         x.m, x.v, x.ill, x.cnt);
            end
        end
    end

    initial begin
        model = '{name: "init", ir: 0, npc: 0, e: 0, w: 0, m: 0, v: 0, ill: 0, cnt: 0};
        reset = 1'b1; enable_decode = 1'b1; Instr_dout = 16'h12A3; npc_in = 16'h3001;

        cycle("reset0", 1, 1, 16'h12A3, 16'h3001, 6'b000000, 2'b00, 0, 0);
        cycle("reset1", 1, 1, 16'h12A3, 16'h3001, 6'b000000, 2'b00, 0, 0);
        cycle("add_imm", 0, 1, 16'h12A3, 16'h3001, 6'b000000, 2'b00, 0, 0);
        for (int i = 0; i < 3; i++)
            cycle("hold", 0, 0, 16'h9FFF, 16'hBEEF, 6'b100000, 2'b00, 0, 0);

        cycle("reset2", 1, 0, 16'h0000, 16'h0000, 6'b000000, 2'b00, 0, 0);
        cycle("and_reg", 0, 1, 16'h5042, 16'h3002, 6'b010001, 2'b00, 0, 0);
        cycle("ldi", 0, 1, 16'hA5FF, 16'h3003, 6'b000110, 2'b10, 1, 0);
        cycle("trap", 0, 1, 16'hF025, 16'h3004, 6'b000000, 2'b00, 0, 1);

        cycle("not", 0, 1, 16'h9FFF, 16'h3005, 6'b100000, 2'b00, 0, 0);
        cycle("and_imm", 0, 1, 16'h5060, 16'h3006, 6'b010000, 2'b00, 0, 0);
        cycle("jmp", 0, 1, 16'hC1C0, 16'h3007, 6'b001100, 2'b00, 0, 0);
        cycle("lea", 0, 1, 16'hE005, 16'h3008, 6'b000110, 2'b01, 0, 0);
        cycle("ldr", 0, 1, 16'h6042, 16'h3009, 6'b001000, 2'b10, 0, 0);
        cycle("str", 0, 1, 16'h7042, 16'h300A, 6'b001000, 2'b00, 0, 0);
        cycle("br", 0, 1, 16'h0E05, 16'h300B, 6'b000110, 2'b00, 0, 0);
        cycle("ld", 0, 1, 16'h2005, 16'h300C, 6'b000110, 2'b10, 0, 0);
        cycle("st", 0, 1, 16'h3005, 16'h300D, 6'b000110, 2'b00, 0, 0);
        cycle("sti", 0, 1, 16'hB005, 16'h300E, 6'b000110, 2'b00, 1, 0);
        cycle("ill_4", 0, 1, 16'h4000, 16'h300F, 6'b000000, 2'b00, 0, 1);
        cycle("ill_8", 0, 1, 16'h8000, 16'h3010, 6'b000000, 2'b00, 0, 1);
        cycle("ill_d", 0, 1, 16'hD000, 16'h3011, 6'b000000, 2'b00, 0, 1);
        cycle("hold_ill", 0, 0, 16'h1000, 16'h0000, 6'b000001, 2'b00, 0, 0);

        cycle("rst_en", 1, 1, 16'hA5FF, 16'h4000, 6'b000110, 2'b10, 1, 0);
        for (int i = 0; i < 65536; i++)
            cycle("wrap", 0, 1, 16'h1000, i[15:0], 6'b000001, 2'b00, 0, 0);
        cycle("post_wrap_hold", 0, 0, 16'h5060, 16'h0000, 6'b010000, 2'b00, 0, 0);

        repeat (3) @(posedge clock);
        #3;
        n_checks++;
        if (q.size() != 0 || n_popped != n_pushed) begin
            n_fail++;
            $display("FAIL drain: got popped=%0d exp pushed=%0d", n_popped, n_pushed);
        end
        n_checks++;
        if (decode_count !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_count: got %h exp 0000", decode_count);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no completion exp finish");
        $fatal(1, "timeout");
    end

endmodule
